// File: rtl/phy_reg_free_list_pkg.sv
// Shared rename-stage configuration and the physical register index type
// used by the free list and the ROB phy_reg/old_phy_reg fields.
package phy_reg_free_list_pkg;

    localparam int unsigned PHY_REG_NUM_CFG  = 64;
    localparam int unsigned ARCH_REG_NUM_CFG = 32;
    localparam int unsigned DECODE_WIDTH     = 2;
    localparam int unsigned COMMIT_WIDTH     = 2;

    typedef logic [$clog2(PHY_REG_NUM_CFG)-1:0] PhyRegIdx;

endpackage

// File: rtl/phy_reg_free_list.sv
// Physical register free list: circular FIFO of preg indices with a speculative
// alloc head, a committed head for flush recovery, and a commit-driven tail.
module phy_reg_free_list
    import phy_reg_free_list_pkg::*;
#(
    parameter int unsigned PHY_REG_NUM  = PHY_REG_NUM_CFG,
    parameter int unsigned ARCH_REG_NUM = ARCH_REG_NUM_CFG,
    parameter int unsigned ALLOC_WIDTH  = DECODE_WIDTH,
    parameter int unsigned FREE_WIDTH   = COMMIT_WIDTH,
    localparam int unsigned FL_DEPTH    = PHY_REG_NUM - ARCH_REG_NUM,
    localparam int unsigned PREG_W      = $clog2(PHY_REG_NUM),
    localparam int unsigned PTR_W       = $clog2(FL_DEPTH) + 1,
    localparam int unsigned IDX_W       = PTR_W - 1
) (
    input  logic                                clk,
    input  logic                                a_rst_n,
    input  logic                                flush_i,
    input  logic [ALLOC_WIDTH-1:0]              alloc_valid_i,
    output logic                                alloc_ready_o,
    output logic [ALLOC_WIDTH-1:0][PREG_W-1:0]  alloc_preg_o,
    input  logic [FREE_WIDTH-1:0]               cmt_valid_i,
    input  logic [FREE_WIDTH-1:0]               cmt_we_i,
    input  logic [FREE_WIDTH-1:0][PREG_W-1:0]   cmt_old_preg_i,
    output logic [PTR_W-1:0]                    free_cnt_o
);

    logic [PREG_W-1:0] fl [FL_DEPTH];
    logic [PTR_W-1:0]  head, cmt_head, tail, cnt;
    logic [PTR_W-1:0]  head_n, cmt_head_n, tail_n, cnt_n;
    logic [PTR_W-1:0]  n_alloc, n_free, alloc_off;
    logic              alloc_fire;
    logic [FREE_WIDTH-1:0] free_en;
    logic [IDX_W-1:0]  free_ptr [FREE_WIDTH];
    logic [PTR_W-1:0]  ptr_gap;

    assign alloc_ready_o = (cnt >= PTR_W'(ALLOC_WIDTH));
    assign free_cnt_o    = cnt;
    assign alloc_fire    = alloc_ready_o & (|alloc_valid_i) & ~flush_i;

    // Valid slots are compacted onto consecutive entries from head
    always_comb begin
        alloc_off = '0;
        for (int unsigned i = 0; i < ALLOC_WIDTH; i++) begin
            alloc_preg_o[i] = fl[IDX_W'(head + alloc_off)];
            if (alloc_valid_i[i]) alloc_off = alloc_off + PTR_W'(1);
        end
        n_alloc = alloc_fire ? alloc_off : '0;
    end

    always_comb begin
        n_free = '0;
        for (int unsigned k = 0; k < FREE_WIDTH; k++) begin
            free_en[k]  = cmt_valid_i[k] & cmt_we_i[k];
            free_ptr[k] = IDX_W'(tail + n_free);
            if (free_en[k]) n_free = n_free + PTR_W'(1);
        end
    end

    // Each committed writer consumed one entry at rename, so frees also advance cmt_head
    always_comb begin
        tail_n     = tail + n_free;
        cmt_head_n = cmt_head + n_free;
        head_n     = flush_i ? cmt_head_n : head + n_alloc;
        cnt_n      = flush_i ? tail_n - cmt_head_n : cnt + n_free - n_alloc;
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            head     <= '0;
            cmt_head <= '0;
            tail     <= {1'b1, {IDX_W{1'b0}}};
            cnt      <= PTR_W'(FL_DEPTH);
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                fl[i] <= PREG_W'(ARCH_REG_NUM + i);
            end
        end else begin
            head     <= head_n;
            cmt_head <= cmt_head_n;
            tail     <= tail_n;
            cnt      <= cnt_n;
            for (int unsigned k = 0; k < FREE_WIDTH; k++) begin
                if (free_en[k]) fl[free_ptr[k]] <= cmt_old_preg_i[k];
            end
        end
    end

    assign ptr_gap = tail - head;

    a_cnt_bound: assert property (@(posedge clk) disable iff (!a_rst_n)
        cnt <= PTR_W'(FL_DEPTH));
    a_no_free_full: assert property (@(posedge clk) disable iff (!a_rst_n)
        (cnt == PTR_W'(FL_DEPTH)) |-> (n_free == '0));
    a_head_behind_tail: assert property (@(posedge clk) disable iff (!a_rst_n)
        ptr_gap <= PTR_W'(FL_DEPTH));

endmodule

// File: tb/tb_phy_reg_free_list.sv
// Self-checking bench for phy_reg_free_list: directed vector table, multi-cycle
// corner sequences, and a randomized run against a queue-based rename model.
module tb_phy_reg_free_list;

    logic             clk = 1'b0;
    logic             a_rst_n;
    logic             flush_i;
    logic [1:0]       alloc_valid_i;
    logic             alloc_ready_o;
    logic [1:0][5:0]  alloc_preg_o;
    logic [1:0]       cmt_valid_i;
    logic [1:0]       cmt_we_i;
    logic [1:0][5:0]  cmt_old_preg_i;
    logic [5:0]       free_cnt_o;

    int checks   = 0;
    int failures = 0;

    phy_reg_free_list #(
        .PHY_REG_NUM (64),
        .ARCH_REG_NUM(32),
        .ALLOC_WIDTH (2),
        .FREE_WIDTH  (2)
    ) dut (
        .clk           (clk),
        .a_rst_n       (a_rst_n),
        .flush_i       (flush_i),
        .alloc_valid_i (alloc_valid_i),
        .alloc_ready_o (alloc_ready_o),
        .alloc_preg_o  (alloc_preg_o),
        .cmt_valid_i   (cmt_valid_i),
        .cmt_we_i      (cmt_we_i),
        .cmt_old_preg_i(cmt_old_preg_i),
        .free_cnt_o    (free_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       flush;
        logic [1:0] av;
        logic [1:0] cv;
        logic [1:0] cwe;
        int         o0;
        int         o1;
        logic       ready;
        int         cnt;
        logic [1:0] pmask;
        int         p0;
        int         p1;
    } vec_t;

    typedef struct {
        int rd;
        int newp;
        int oldp;
    } inst_t;

    // Rename model: free list and committed free list as queues of pregs
    int    fq[$];
    int    cq[$];
    inst_t inflight[$];
    int    arch_rat[32];
    int    spec_rat[32];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        flush_i        = 1'b0;
        alloc_valid_i  = 2'b00;
        cmt_valid_i    = 2'b00;
        cmt_we_i       = 2'b00;
        cmt_old_preg_i = '0;
    endtask

    task automatic reset_all();
        idle_inputs();
        a_rst_n = 1'b0;
        #12;
        @(negedge clk);
        a_rst_n = 1'b1;
        fq.delete();
        cq.delete();
        inflight.delete();
        for (int i = 0; i < 32; i++) begin
            fq.push_back(32 + i);
            cq.push_back(32 + i);
            arch_rat[i] = i;
            spec_rat[i] = i;
        end
    endtask

    task automatic step(input string nm, input logic fl, input logic [1:0] av,
                        input logic [1:0] cv, input logic [1:0] cwe, input int o0, input int o1,
                        input logic er, input int ec, input logic [1:0] pm, input int p0, input int p1);
        @(negedge clk);
        flush_i           = fl;
        alloc_valid_i     = av;
        cmt_valid_i       = cv;
        cmt_we_i          = cwe;
        cmt_old_preg_i[0] = 6'(o0);
        cmt_old_preg_i[1] = 6'(o1);
        #1;
        chk({nm, ".ready"}, int'(alloc_ready_o), int'(er));
        chk({nm, ".free_cnt"}, int'(free_cnt_o), ec);
        if (pm[0]) chk({nm, ".preg0"}, int'(alloc_preg_o[0]), p0);
        if (pm[1]) chk({nm, ".preg1"}, int'(alloc_preg_o[1]), p1);
    endtask

    vec_t vecs[7];

    initial begin
        // Reset state shown with both slots requesting; flush drops that allocation
        vecs[0] = '{1'b1, 2'b11, 2'b00, 2'b00, 0, 0, 1'b1, 32, 2'b11, 32, 33};
        vecs[1] = '{1'b0, 2'b10, 2'b00, 2'b00, 0, 0, 1'b1, 32, 2'b10, 0, 32};
        vecs[2] = '{1'b0, 2'b00, 2'b00, 2'b00, 0, 0, 1'b1, 31, 2'b01, 33, 0};
        vecs[3] = '{1'b0, 2'b01, 2'b00, 2'b00, 0, 0, 1'b1, 31, 2'b01, 33, 0};
        vecs[4] = '{1'b0, 2'b00, 2'b11, 2'b10, 0, 40, 1'b1, 30, 2'b11, 34, 34};
        vecs[5] = '{1'b0, 2'b11, 2'b00, 2'b00, 0, 0, 1'b1, 31, 2'b11, 34, 35};
        vecs[6] = '{1'b0, 2'b00, 2'b00, 2'b00, 0, 0, 1'b1, 29, 2'b11, 36, 36};

        reset_all();
        for (int v = 0; v < 7; v++) begin
            step($sformatf("vec%0d", v), vecs[v].flush, vecs[v].av, vecs[v].cv, vecs[v].cwe,
                 vecs[v].o0, vecs[v].o1, vecs[v].ready, vecs[v].cnt, vecs[v].pmask,
                 vecs[v].p0, vecs[v].p1);
        end

        // Drain to empty, then refill one entry at a time (whole-group ready)
        reset_all();
        for (int c = 0; c < 16; c++)
            step("drain", 1'b0, 2'b11, 2'b00, 2'b00, 0, 0, 1'b1, 32 - 2 * c, 2'b11, 32 + 2 * c, 33 + 2 * c);
        step("empty_free5", 1'b0, 2'b11, 2'b01, 2'b01, 5, 0, 1'b0, 0, 2'b00, 0, 0);
        step("one_free7", 1'b0, 2'b11, 2'b01, 2'b01, 7, 0, 1'b0, 1, 2'b00, 0, 0);
        step("refill", 1'b0, 2'b11, 2'b00, 2'b00, 0, 0, 1'b1, 2, 2'b11, 5, 7);
        step("after_refill", 1'b0, 2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 0, 2'b00, 0, 0);

        // Allocate 6, commit 2 writers, flush restores to the committed head
        reset_all();
        for (int c = 0; c < 3; c++)
            step("alloc6", 1'b0, 2'b11, 2'b00, 2'b00, 0, 0, 1'b1, 32 - 2 * c, 2'b11, 32 + 2 * c, 33 + 2 * c);
        step("commit2", 1'b0, 2'b00, 2'b11, 2'b11, 3, 4, 1'b1, 26, 2'b00, 0, 0);
        step("flush", 1'b1, 2'b00, 2'b00, 2'b00, 0, 0, 1'b1, 28, 2'b00, 0, 0);
        step("post_flush", 1'b0, 2'b11, 2'b00, 2'b00, 0, 0, 1'b1, 32, 2'b11, 34, 35);

        // Flush with a simultaneous allocation and commit free
        reset_all();
        for (int c = 0; c < 2; c++)
            step("alloc4", 1'b0, 2'b11, 2'b00, 2'b00, 0, 0, 1'b1, 32 - 2 * c, 2'b11, 32 + 2 * c, 33 + 2 * c);
        step("flush_alloc", 1'b1, 2'b11, 2'b01, 2'b01, 9, 0, 1'b1, 28, 2'b11, 36, 37);
        step("flush_restore", 1'b0, 2'b11, 2'b00, 2'b00, 0, 0, 1'b1, 32, 2'b11, 33, 34);
        step("after_restore", 1'b0, 2'b00, 2'b00, 2'b00, 0, 0, 1'b1, 30, 2'b00, 0, 0);

        // Randomized run against the rename model
        reset_all();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic       rf;
            logic [1:0] av, cv, cwe;
            int         op[2];
            int         used, off, p;
            logic       exp_ready;
            inst_t      e;

            used = 0;
            rf   = ($urandom_range(0, 39) == 0);
            av   = 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                cv[k] = 1'($urandom_range(0, 1));
                if (cv[k] && used < inflight.size() && $urandom_range(0, 3) != 0) begin
                    cwe[k] = 1'b1;
                    op[k]  = inflight[used].oldp;
                    used++;
                end else begin
                    cwe[k] = 1'b0;
                    op[k]  = int'($urandom_range(0, 63));
                end
            end

            @(negedge clk);
            flush_i           = rf;
            alloc_valid_i     = av;
            cmt_valid_i       = cv;
            cmt_we_i          = cwe;
            cmt_old_preg_i[0] = 6'(op[0]);
            cmt_old_preg_i[1] = 6'(op[1]);
            #1;
            exp_ready = (fq.size() >= 2);
            chk("rnd.ready", int'(alloc_ready_o), int'(exp_ready));
            chk("rnd.free_cnt", int'(free_cnt_o), fq.size());

            off = 0;
            if (exp_ready && !rf) begin
                for (int i = 0; i < 2; i++) begin
                    if (av[i]) begin
                        p = int'(alloc_preg_o[i]);
                        chk("rnd.preg", p, fq[off]);
                        off++;
                        e.rd   = int'($urandom_range(1, 31));
                        e.newp = p;
                        e.oldp = spec_rat[e.rd];
                        spec_rat[e.rd] = p;
                        inflight.push_back(e);
                    end
                end
            end else if (exp_ready) begin
                for (int i = 0; i < 2; i++)
                    if (av[i]) begin
                        chk("rnd.preg_flush", int'(alloc_preg_o[i]), fq[off]);
                        off++;
                    end
                off = 0;
            end

            // Commits retire the oldest in-flight instructions (allocated in earlier cycles)
            for (int k = 0; k < 2; k++) begin
                if (cwe[k]) begin
                    e = inflight.pop_front();
                    arch_rat[e.rd] = e.newp;
                    void'(cq.pop_front());
                    cq.push_back(e.oldp);
                    fq.push_back(e.oldp);
                end
            end
            for (int i = 0; i < off; i++) void'(fq.pop_front());

            if (rf) begin
                inflight.delete();
                for (int r = 0; r < 32; r++) spec_rat[r] = arch_rat[r];
                fq = cq;
            end

            if (cyc % 64 == 63) begin
                int seen[64];
                int bad;
                bad = 0;
                for (int i = 0; i < 64; i++) seen[i] = 0;
                for (int r = 0; r < 32; r++) seen[spec_rat[r] & 63]++;
                foreach (fq[i]) seen[fq[i] & 63]++;
                foreach (inflight[i]) seen[inflight[i].oldp & 63]++;
                for (int i = 0; i < 64; i++) if (seen[i] != 1) bad++;
                chk("rnd.ownership", bad, 0);
            end
        end

        // Asynchronous reset mid-operation
        @(negedge clk);
        idle_inputs();
        alloc_valid_i = 2'b11;
        #2;
        a_rst_n = 1'b0;
        #1;
        chk("async_rst.free_cnt", int'(free_cnt_o), 32);
        chk("async_rst.ready", int'(alloc_ready_o), 1);
        chk("async_rst.preg0", int'(alloc_preg_o[0]), 32);
        chk("async_rst.preg1", int'(alloc_preg_o[1]), 33);
        @(negedge clk);
        a_rst_n = 1'b1;
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
